// File: rtl/addsub_bist.sv
// Built-in self-test engine for a combinational 32-bit adder/subtractor.
// It drives directed vectors and then LFSR vectors, compares each sum and records failures.
module addsub_bist #(
  parameter int unsigned NUM_VECTORS   = 256,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [31:0] SEED          = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dut_sum,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_sub,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_fail
);

  localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF    = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [15:0] LAST_INDEX  = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t      state;
  logic [15:0] index;
  logic [31:0] lfsr;
  logic [31:0] expected;
  logic [3:0]  settle;

  logic [31:0] vec_a;
  logic [31:0] vec_b;
  logic        vec_sub;
  logic [31:0] vec_expected;
  logic [31:0] lfsr_next;
  logic        mismatch;
  logic [15:0] err_next;

  // Indices 0-7 come from the directed table, everything above from the LFSR.
  always_comb begin
    vec_a   = lfsr;
    vec_b   = {lfsr[15:0], lfsr[31:16]};
    vec_sub = lfsr[0] ^ lfsr[31];
    if (index < 16'd8) begin
      unique case (index[2:0])
        3'd0: begin vec_a = 32'h0000_0000; vec_b = 32'h0000_0000; vec_sub = 1'b0; end
        3'd1: begin vec_a = 32'h0000_0001; vec_b = 32'h0000_0000; vec_sub = 1'b0; end
        3'd2: begin vec_a = 32'h0000_0002; vec_b = 32'h0000_0000; vec_sub = 1'b0; end
        3'd3: begin vec_a = 32'h0000_0002; vec_b = 32'h0000_0001; vec_sub = 1'b1; end
        3'd4: begin vec_a = 32'h0000_0002; vec_b = 32'h0000_0002; vec_sub = 1'b1; end
        3'd5: begin vec_a = 32'h0000_FFFF; vec_b = 32'h0000_0001; vec_sub = 1'b0; end
        3'd6: begin vec_a = 32'h0001_0000; vec_b = 32'h0000_0001; vec_sub = 1'b1; end
        3'd7: begin vec_a = 32'hFFFF_FFFF; vec_b = 32'hFFFF_FFFF; vec_sub = 1'b0; end
      endcase
    end
  end

  assign vec_expected = vec_sub ? (vec_a - vec_b) : (vec_a + vec_b);
  assign lfsr_next    = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'd0);
  assign mismatch     = (dut_sum != expected);
  assign err_next     = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

  // Sequencer: every vector spends one cycle in APPLY, SETTLE_CYCLES in WAIT and one in CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      op_sub     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 16'd0;
      first_fail <= 16'hFFFF;
      lfsr       <= SEED_EFF;
      index      <= 16'd0;
      expected   <= 32'd0;
      settle     <= 4'd0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_count  <= 16'd0;
            first_fail <= 16'hFFFF;
            index      <= 16'd0;
            lfsr       <= SEED_EFF;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= S_APPLY;
          end
        end
        S_APPLY: begin
          op_a     <= vec_a;
          op_b     <= vec_b;
          op_sub   <= vec_sub;
          expected <= vec_expected;
          if (index >= 16'd8) begin
            lfsr <= lfsr_next;
          end
          settle <= SETTLE_LOAD;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          settle <= settle - 4'd1;
          if (settle <= 4'd1) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          // A zero error count means this mismatch is the first one of the run.
          if (mismatch) begin
            err_count <= err_next;
            if (err_count == 16'd0) begin
              first_fail <= index;
            end
          end
          if (index == LAST_INDEX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (err_count == 16'd0);
            state <= S_DONE;
          end else begin
            index <= index + 16'd1;
            state <= S_APPLY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
